fetch_stall_ctrl: RTL and testbench

Front-end pipeline control that consumes the hazard unit's stall/flush decisions and applies them. It owns the PC register, the IF/ID register, and the control half of the ID/EX register. It also applies ID-stage branch redirects, and keeps saturating stall and flush event counters for debug. It sits between instruction memory and the decode stage of the five-stage MIPS pipeline.

---
 rtl/pipeline_pkg.sv | 7 +
 rtl/sat_counter.sv | 23 ++
 rtl/fetch_stall_ctrl.sv | 78 +++++++
 tb/tb_fetch_stall_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared constants and types for the front-end pipeline control
package pipeline_pkg;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          CTRL_W           = 9;
    typedef logic [CTRL_W-1:0] id_ex_ctrl_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with synchronous clear
//   clock_in, reset_in (async, active-high), clear_in (sync clear, beats inc_in),
//   inc_in (count one event), count_out (holds at all-ones)
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock_in,
    input  logic         reset_in,
    input  logic         clear_in,
    input  logic         inc_in,
    output logic [W-1:0] count_out
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in)
            r_cnt <= '0;
        else if (clear_in)
            r_cnt <= '0;
        else if (inc_in && ~&r_cnt)
            r_cnt <= r_cnt + W'(1);
    end
    assign count_out = r_cnt;
endmodule

// File: rtl/fetch_stall_ctrl.sv
// fetch_stall_ctrl: applies hazard-unit stalls/flushes and ID branch redirects to PC, IF/ID and ID/EX control
//   inputs : clock_in, reset_in (async, active-high), pc_wr_in, if_id_wr_in, flush_control_in,
//            branch_taken_in, branch_target_in, instruction_in, id_ex_ctrl_in, counter_clear_in
//   outputs: pc_out, if_id_instruction_out, if_id_pc4_out, if_id_valid_out, id_ex_ctrl_out,
//            stall_count_out, flush_count_out (all registered)
module fetch_stall_ctrl #(
    parameter logic [31:0] RESET_PC = pipeline_pkg::DEFAULT_RESET_PC,
    parameter int          CTRL_W   = pipeline_pkg::CTRL_W,
    parameter int          CNT_W    = 16
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              pc_wr_in,
    input  logic              if_id_wr_in,
    input  logic              flush_control_in,
    input  logic              branch_taken_in,
    input  logic [31:0]       branch_target_in,
    input  logic [31:0]       instruction_in,
    input  logic [CTRL_W-1:0] id_ex_ctrl_in,
    input  logic              counter_clear_in,
    output logic [31:0]       pc_out,
    output logic [31:0]       if_id_instruction_out,
    output logic [31:0]       if_id_pc4_out,
    output logic              if_id_valid_out,
    output logic [CTRL_W-1:0] id_ex_ctrl_out,
    output logic [CNT_W-1:0]  stall_count_out,
    output logic [CNT_W-1:0]  flush_count_out
);
    logic [31:0]       r_pc;
    logic [31:0]       r_if_id_instr;
    logic [31:0]       r_if_id_pc4;
    logic              r_if_id_valid;
    logic [CTRL_W-1:0] r_id_ex_ctrl;
    logic              w_redirect;
    logic [31:0]       w_pc4;
    logic [31:0]       w_target;
    // a branch seen while the PC is stalled is waiting on an operand and will be re-presented
    assign w_redirect = pc_wr_in & branch_taken_in;
    assign w_pc4      = r_pc + 32'd4;
    assign w_target   = branch_target_in & ~32'd3;
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_pc          <= RESET_PC;
            r_if_id_instr <= pipeline_pkg::NOP_INSTR;
            r_if_id_pc4   <= '0;
            r_if_id_valid <= 1'b0;
            r_id_ex_ctrl  <= '0;
        end else begin
            if (pc_wr_in)
                r_pc <= w_redirect ? w_target : w_pc4;
            if (if_id_wr_in) begin
                r_if_id_instr <= w_redirect ? pipeline_pkg::NOP_INSTR : instruction_in;
                r_if_id_pc4   <= w_pc4;
                r_if_id_valid <= ~w_redirect;
            end
            r_id_ex_ctrl <= flush_control_in ? '0 : id_ex_ctrl_in;
        end
    end
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .clear_in (counter_clear_in),
        .inc_in   (flush_control_in),
        .count_out(stall_count_out)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .clear_in (counter_clear_in),
        .inc_in   (w_redirect & if_id_wr_in),
        .count_out(flush_count_out)
    );
    assign pc_out                = r_pc;
    assign if_id_instruction_out = r_if_id_instr;
    assign if_id_pc4_out         = r_if_id_pc4;
    assign if_id_valid_out       = r_if_id_valid;
    assign id_ex_ctrl_out        = r_id_ex_ctrl;
endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// tb_fetch_stall_ctrl: scoreboard bench for fetch_stall_ctrl with directed vectors
module tb_fetch_stall_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        pcw, ifw, fl, bt, clr;
    logic [31:0] tgt, ins;
    logic [8:0]  ctl;
    logic [31:0] pc, id_ins, id_pc4;
    logic        id_v;
    logic [8:0]  ex_ctl;
    logic [1:0]  scnt, fcnt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pc4;
        logic        v;
        logic [8:0]  ctl;
        logic [1:0]  sc;
        logic [1:0]  fc;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_vec = 0;

    always #5 clk = ~clk;

    fetch_stall_ctrl #(.RESET_PC(32'h100), .CTRL_W(9), .CNT_W(2)) dut (
        .clock_in             (clk),
        .reset_in             (rst),
        .pc_wr_in             (pcw),
        .if_id_wr_in          (ifw),
        .flush_control_in     (fl),
        .branch_taken_in      (bt),
        .branch_target_in     (tgt),
        .instruction_in       (ins),
        .id_ex_ctrl_in        (ctl),
        .counter_clear_in     (clr),
        .pc_out               (pc),
        .if_id_instruction_out(id_ins),
        .if_id_pc4_out        (id_pc4),
        .if_id_valid_out      (id_v),
        .id_ex_ctrl_out       (ex_ctl),
        .stall_count_out      (scnt),
        .flush_count_out      (fcnt)
    );

    function automatic exp_t mk(logic [31:0] p, logic [31:0] i, logic [31:0] p4, logic v,
                                logic [8:0] c, logic [1:0] s, logic [1:0] f);
        exp_t e;
        e.pc = p; e.ins = i; e.pc4 = p4; e.v = v; e.ctl = c; e.sc = s; e.fc = f;
        return e;
    endfunction

    task automatic chk(int vec, string name, logic [31:0] act, logic [31:0] want);
        n_total++;
        if (act !== want)
            $display("FAIL vec%0d %s: got %h expected %h", vec, name, act, want);
        else
            n_pass++;
    endtask

    // monitor: each clock edge (or an explicit mid-cycle request) consumes one expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                n_vec++;
                chk(n_vec, "pc",        pc,            e.pc);
                chk(n_vec, "if_id_ins", id_ins,        e.ins);
                chk(n_vec, "if_id_pc4", id_pc4,        e.pc4);
                chk(n_vec, "if_id_v",   {31'd0, id_v}, {31'd0, e.v});
                chk(n_vec, "ex_ctrl",   {23'd0, ex_ctl}, {23'd0, e.ctl});
                chk(n_vec, "stall_cnt", {30'd0, scnt}, {30'd0, e.sc});
                chk(n_vec, "flush_cnt", {30'd0, fcnt}, {30'd0, e.fc});
            end
        end
    end

    // drive inputs now, queue the state expected after the coming edge, move to next negedge
    task automatic step(logic a_pcw, logic a_ifw, logic a_fl, logic a_bt, logic a_clr,
                        logic [31:0] a_tgt, logic [31:0] a_ins, logic [8:0] a_ctl, exp_t e);
        pcw = a_pcw; ifw = a_ifw; fl = a_fl; bt = a_bt; clr = a_clr;
        tgt = a_tgt; ins = a_ins; ctl = a_ctl;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        pcw = 1'b1; ifw = 1'b1; fl = 1'b0; bt = 1'b0; clr = 1'b0;
        tgt = '0; ins = '0; ctl = '0;
        #2;
        q.push_back(mk(32'h100, 0, 0, 0, 0, 0, 0));
        ->chk_ev;
        @(negedge clk);
        rst = 1'b0;
        // free run from RESET_PC
        step(1,1,0,0,0, 0, 32'h11111111, 9'h1A5, mk(32'h104, 32'h11111111, 32'h104, 1, 9'h1A5, 0, 0));
        step(1,1,0,0,0, 0, 32'h22222222, 9'h0F0, mk(32'h108, 32'h22222222, 32'h108, 1, 9'h0F0, 0, 0));
        step(1,1,0,0,0, 0, 32'h33333333, 9'h155, mk(32'h10C, 32'h33333333, 32'h10C, 1, 9'h155, 0, 0));
        // redirect to 0x1C, then fetch to 0x20
        step(1,1,0,1,0, 32'h1C, 32'h44444444, 9'h003, mk(32'h01C, 0, 32'h110, 0, 9'h003, 0, 1));
        step(1,1,0,0,0, 0, 32'h55555555, 9'h0AA, mk(32'h020, 32'h55555555, 32'h020, 1, 9'h0AA, 0, 1));
        // load-use stall at 0x20
        step(0,0,1,0,0, 0, 32'h66666666, 9'h1FF, mk(32'h020, 32'h55555555, 32'h020, 1, 9'h000, 1, 1));
        step(1,1,0,0,0, 0, 32'h77777777, 9'h011, mk(32'h024, 32'h77777777, 32'h024, 1, 9'h011, 1, 1));
        // clear beats simultaneous increment
        step(1,1,1,0,1, 0, 32'h88888888, 9'h0CC, mk(32'h028, 32'h88888888, 32'h028, 1, 9'h000, 0, 0));
        // branch to 0x40, then taken branch at 0x40 with misaligned target 0x203
        step(1,1,0,1,0, 32'h40, 32'h99999999, 9'h002, mk(32'h040, 0, 32'h02C, 0, 9'h002, 0, 1));
        step(1,1,0,1,0, 32'h203, 32'hAAAAAAAA, 9'h004, mk(32'h200, 0, 32'h044, 0, 9'h004, 0, 2));
        // branch during full stall: ignored
        step(0,0,1,1,0, 32'h300, 32'hBBBBBBBB, 9'h1F0, mk(32'h200, 0, 32'h044, 0, 9'h000, 1, 2));
        // PC held, IF/ID written: unqualified branch does not squash
        step(0,1,0,1,0, 32'h300, 32'hCCCCCCCC, 9'h008, mk(32'h200, 32'hCCCCCCCC, 32'h204, 1, 9'h008, 1, 2));
        // same branch with PC enabled: redirect
        step(1,1,0,1,0, 32'h300, 32'hDDDDDDDD, 9'h010, mk(32'h300, 0, 32'h204, 0, 9'h010, 1, 3));
        // flush counter saturates; target low bits dropped
        step(1,1,0,1,0, 32'hFFFFFFFF, 32'h12345678, 9'h040, mk(32'hFFFFFFFC, 0, 32'h304, 0, 9'h040, 1, 3));
        // PC wraps to 0
        step(1,1,0,0,0, 0, 32'h0BADF00D, 9'h080, mk(32'h000, 32'h0BADF00D, 32'h000, 1, 9'h080, 1, 3));
        // stall counter saturation over 5 flush cycles
        step(1,1,1,0,0, 0, 32'h01010101, 9'h1FF, mk(32'h004, 32'h01010101, 32'h004, 1, 9'h000, 2, 3));
        step(1,1,1,0,0, 0, 32'h01010101, 9'h1FF, mk(32'h008, 32'h01010101, 32'h008, 1, 9'h000, 3, 3));
        step(1,1,1,0,0, 0, 32'h01010101, 9'h1FF, mk(32'h00C, 32'h01010101, 32'h00C, 1, 9'h000, 3, 3));
        step(1,1,1,0,0, 0, 32'h01010101, 9'h1FF, mk(32'h010, 32'h01010101, 32'h010, 1, 9'h000, 3, 3));
        step(1,1,1,0,0, 0, 32'h01010101, 9'h1FF, mk(32'h014, 32'h01010101, 32'h014, 1, 9'h000, 3, 3));
        step(1,1,0,0,1, 0, 32'h02020202, 9'h100, mk(32'h018, 32'h02020202, 32'h018, 1, 9'h100, 0, 0));
        // PC advances while IF/ID holds
        step(1,0,0,0,0, 0, 32'h03030303, 9'h101, mk(32'h01C, 32'h02020202, 32'h018, 1, 9'h101, 0, 0));
        // redirect with IF/ID held: no squash, not counted
        step(1,0,0,1,0, 32'h500, 32'h03030303, 9'h102, mk(32'h500, 32'h02020202, 32'h018, 1, 9'h102, 0, 0));
        // stall, then async reset between edges
        step(0,0,1,0,0, 0, 32'h04040404, 9'h0FF, mk(32'h500, 32'h02020202, 32'h018, 1, 9'h000, 1, 0));
        #2;
        rst = 1'b1;
        q.push_back(mk(32'h100, 0, 0, 0, 0, 0, 0));
        ->chk_ev;
        q.push_back(mk(32'h100, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        // first edge after reset fetches from RESET_PC
        step(1,1,0,0,0, 0, 32'h04040404, 9'h00F, mk(32'h104, 32'h04040404, 32'h104, 1, 9'h00F, 0, 0));
        repeat (3) @(negedge clk);
        n_total++;
        if (q.size() != 0)
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
